// File: rtl/fir_window_table_loader.sv
// fir_window_table_loader: walks a window generator over n taps, stores the samples in RAM and sums them.
module fir_window_table_loader #(
  parameter int MAX_LGN = 10,
  parameter int TIMEOUT = 4096
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [3:0]                win_type_in,
  input  logic [7:0]                lgn_in,
  output logic                      gen_en,
  output logic [3:0]                gen_win_type,
  output logic [15:0]               gen_n,
  output logic [7:0]                gen_lgn,
  output logic [15:0]               gen_i,
  input  logic                      gen_busy,
  input  logic signed [15:0]        gen_win,
  input  logic [MAX_LGN-1:0]        rd_addr,
  output logic signed [15:0]        rd_data,
  output logic                      table_valid,
  output logic                      build_busy,
  output logic                      done,
  output logic                      err,
  output logic signed [31:0]        coef_sum
);
  typedef enum logic [2:0] {IDLE, SETUP, REQ, WAIT, WRITE, FIN} state_t;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [7:0] MAXL = 8'(MAX_LGN);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  state_t state_q, state_d;
  logic [3:0] type_q, type_d;
  logic [15:0] n_q, n_d, i_q, i_d;
  logic [7:0] lgn_q, lgn_d;
  logic tv_q, tv_d, err_q, err_d, we;
  logic signed [31:0] sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic signed [15:0] ram [2**MAX_LGN];
  logic signed [15:0] rd_q;
  logic lgn_bad, timed_out;
  assign lgn_bad = (lgn_in == 8'd0) || (lgn_in > MAXL);
  assign timed_out = cnt_q == TO_LAST;
  always_comb begin
    state_d = state_q;
    type_d = type_q;
    n_d = n_q;
    lgn_d = lgn_q;
    i_d = i_q;
    tv_d = tv_q;
    err_d = err_q;
    sum_d = sum_q;
    cnt_d = cnt_q + 1'b1;
    we = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        tv_d = 1'b0;
        err_d = lgn_bad;
        if (!lgn_bad) begin
          type_d = win_type_in;
          lgn_d = lgn_in;
          n_d = 16'd1 << lgn_in;
          sum_d = '0;
          i_d = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d = '0;
        state_d = REQ;
      end
      REQ: if (gen_busy) begin
        cnt_d = '0;
        state_d = WAIT;
      end else if (timed_out) begin
        err_d = 1'b1;
        state_d = IDLE;
      end
      WAIT: if (!gen_busy) begin
        state_d = WRITE;
      end else if (timed_out) begin
        err_d = 1'b1;
        state_d = IDLE;
      end
      WRITE: begin
        we = 1'b1;
        sum_d = sum_q + 32'(gen_win);
        cnt_d = '0;
        // table_valid is raised here so it rises together with done on entry to FIN
        tv_d = i_q == n_q - 16'd1;
        i_d = tv_d ? i_q : i_q + 16'd1;
        state_d = tv_d ? FIN : REQ;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      type_q <= '0;
      n_q <= '0;
      lgn_q <= '0;
      i_q <= '0;
      tv_q <= 1'b0;
      err_q <= 1'b0;
      sum_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      type_q <= type_d;
      n_q <= n_d;
      lgn_q <= lgn_d;
      i_q <= i_d;
      tv_q <= tv_d;
      err_q <= err_d;
      sum_q <= sum_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) if (we) ram[i_q[MAX_LGN-1:0]] <= gen_win;
  always_ff @(posedge clk) rd_q <= rst ? 16'sd0 : ram[rd_addr];
  assign gen_en = state_q == REQ;
  assign gen_win_type = type_q;
  assign gen_n = n_q;
  assign gen_lgn = lgn_q;
  assign gen_i = i_q;
  assign rd_data = rd_q;
  assign table_valid = tv_q;
  assign build_busy = state_q != IDLE;
  assign done = state_q == FIN;
  assign err = err_q;
  assign coef_sum = sum_q;
endmodule
